es_ports: RTL
=============

Name: es_ports

Overview:
- Peripheral I/O stage between the microcontroller datapath and the external world.
- Consumes the core's output-side signals (data_mem, data_reg, id_out) and drives four latched 8-bit output ports.
- Buffers four external 8-bit input channels in small FIFOs and returns the selected channel's head word on data_in, which the core muxes into the register file.

Parameters:
- DEPTH, 4, entries per input FIFO; power of two, at least 2.
- PORT_W, 8, data width of every port; must match the core datapath.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- data_mem  in  8  immediate word from the core, memprog[11:4].
- data_reg  in  8  register word from the core, rd1.
- id_out  in  2  output port select.
- id_in  in  2  input port select.
- we_out  in  1  from UC: write output port id_out this cycle.
- s_src  in  1  from UC: 0 selects data_mem, 1 selects data_reg.
- re_in  in  1  from UC: consume the head of input FIFO id_in this cycle.
- data_in  out  8  to the core: head of FIFO id_in; 0 when that FIFO is empty. Combinational.
- in_avail  out  1  FIFO id_in is non-empty. Combinational.
- ext_in  in  32  four input channels; channel k is bits [8k+7:8k].
- ext_in_valid  in  4  per-channel valid.
- ext_in_ready  out  4  per-channel ready; equals not-full.
- port_out  out  32  four output registers; port k is bits [8k+7:8k].
- out_stb  out  4  one-cycle write strobe per output port.
- err  out  4  sticky underflow flags; see Optional Feature.

Behaviour:
- Reset:
  - Clears all FIFO pointers and counts, port_out, out_stb and err to 0.
  - Outputs after reset: ext_in_ready = 4'hF, in_avail = 0, data_in = 0.
  - Reset asserted mid-transfer discards buffered data. A push or pop in that same cycle is ignored.
- Output path:
  - When we_out=1, port_out[id_out] <= (s_src ? data_reg : data_mem) at the clock edge.
  - out_stb[id_out] is registered: high for exactly one cycle, aligned with the new port value.
  - Other ports hold their value.
  - Back-to-back writes to the same port give a strobe every cycle and the last value wins.
- Input push: channel k pushes ext_in[k] when ext_in_valid[k] && ext_in_ready[k]. The word is visible at the head one cycle later, no bypass.
- Input pop:
  - When re_in=1 and FIFO id_in is non-empty, the head advances at the clock edge.
  - data_in shows the current head during the pop cycle; the core captures it in that same cycle.
- Simultaneous push and pop, same channel:
  - Non-empty FIFO: both occur and the count is unchanged.
  - Empty FIFO: the push occurs, the pop is an underflow.
  - Full FIFO: ready is low, so only the pop occurs. ready rises the next cycle.
- Underflow: re_in on an empty FIFO changes no pointer, and data_in reads 0.
- Pointers wrap modulo DEPTH. Count width is $clog2(DEPTH)+1.
- Full means count == DEPTH.
- The output and input paths are independent. we_out and re_in may both be active in the same cycle.

Optional Feature:
- Macro: ES_UNDERFLOW_ERR_EN.
- Enabled:
  - An underflow on channel k sets err[k] at the clock edge.
  - err[k] is sticky and is cleared only by reset.
- Disabled: err is tied to 4'b0 and no flops are inferred.

Decomposition:
- Package es_pkg holds:
  - NPORTS=4, PORT_W=8, ID_W=2;
  - a typedef for the port word;
  - a typedef for the port id.
- Sub-module es_fifo: single-clock synchronous FIFO.
  - Parameters DEPTH and PORT_W.
  - Ports: push, pop, din, dout (head), empty, full, underflow.
  - Instantiated NPORTS times via generate.
- The top level contains the output registers, the strobes, the read mux and the err logic.

Test Plan:
- Reset then idle -> port_out=0, out_stb=0, ext_in_ready=4'hF, in_avail=0, data_in=8'h00.
- we_out=1, s_src=0, data_mem=8'hA5, id_out=2 -> next cycle port_out[23:16]=8'hA5, out_stb=4'b0100 for one cycle; then s_src=1, data_reg=8'h3C -> port 2 becomes 8'h3C.
- Push 8'h11, 8'h22, 8'h33, 8'h44 on channel 1 -> ext_in_ready[1]=0 after the 4th push; a 5th valid word is not accepted; pops with id_in=1 return 11, 22, 33, 44 in order; ready[1]=1 the cycle after the first pop.
- Full channel 0, then push and pop in the same cycle -> only the pop is taken; count=3, ready[0]=1 on the following cycle.
- re_in=1 on empty channel 3 -> data_in=0, pointers unchanged; err=4'b1000 with ES_UNDERFLOW_ERR_EN, err=0 without it; err persists until reset.
- Assert reset with 2 words in channel 2 and a pending write -> after reset in_avail=0 for id_in=2, port_out=0, out_stb=0.

Source files
------------

// File: rtl/es_pkg.sv
// Shared types and constants for the es_ports peripheral I/O stage.
package es_pkg;

  localparam int NPORTS = 4;
  localparam int PORT_W = 8;
  localparam int ID_W   = 2;

  typedef logic [PORT_W-1:0] port_word_t;
  typedef logic [ID_W-1:0]   port_id_t;

endpackage

// File: rtl/es_fifo.sv
// Single-clock synchronous FIFO for one external input channel.
// dout shows the head word, or zero when empty; there is no push-to-head bypass.
module es_fifo #(
  parameter int DEPTH  = 4,
  parameter int PORT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [PORT_W-1:0] din,
  output logic [PORT_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic              underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PORT_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              do_push;
  logic              do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign underflow = pop && empty;
  assign dout      = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/es_ports.sv
// Peripheral I/O stage: four latched output ports with write strobes and four
// buffered input channels. Define ES_UNDERFLOW_ERR_EN for sticky underflow flags.
module es_ports
  import es_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PORT_W-1:0]        data_mem,
  input  logic [PORT_W-1:0]        data_reg,
  input  logic [ID_W-1:0]          id_out,
  input  logic [ID_W-1:0]          id_in,
  input  logic                     we_out,
  input  logic                     s_src,
  input  logic                     re_in,
  output logic [PORT_W-1:0]        data_in,
  output logic                     in_avail,
  input  logic [NPORTS*PORT_W-1:0] ext_in,
  input  logic [NPORTS-1:0]        ext_in_valid,
  output logic [NPORTS-1:0]        ext_in_ready,
  output logic [NPORTS*PORT_W-1:0] port_out,
  output logic [NPORTS-1:0]        out_stb,
  output logic [NPORTS-1:0]        err
);

  port_word_t        port_q [NPORTS];
  port_word_t        head   [NPORTS];
  logic [NPORTS-1:0] empty;
  logic [NPORTS-1:0] full;
  logic [NPORTS-1:0] underflow;
  port_word_t        wr_word;

  assign wr_word = s_src ? data_reg : data_mem;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NPORTS; k++) port_q[k] <= '0;
      out_stb <= '0;
    end else begin
      out_stb <= '0;
      if (we_out) begin
        port_q[id_out]  <= wr_word;
        out_stb[id_out] <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NPORTS; k++) begin : g_ch
    es_fifo #(
      .DEPTH  (DEPTH),
      .PORT_W (PORT_W)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (ext_in_valid[k] && ext_in_ready[k]),
      .pop       (re_in && (id_in == port_id_t'(k))),
      .din       (ext_in[k*PORT_W +: PORT_W]),
      .dout      (head[k]),
      .empty     (empty[k]),
      .full      (full[k]),
      .underflow (underflow[k])
    );
    assign port_out[k*PORT_W +: PORT_W] = port_q[k];
    assign ext_in_ready[k]              = !full[k];
  end

  // The FIFO already returns zero on empty, so the read mux needs no extra gating.
  assign data_in  = head[id_in];
  assign in_avail = !empty[id_in];

`ifdef ES_UNDERFLOW_ERR_EN
  always_ff @(posedge clk) begin
    if (reset) err <= '0;
    else       err <= err | underflow;
  end
`else
  logic unused_underflow;
  assign unused_underflow = |underflow;
  assign err              = '0;
`endif

endmodule
